// File: rtl/apb_master_gen.sv
// APB4 master: bridges a valid/ready processor request onto a shared APB bus with
// NUM_SLAVES select lines. Supports strobes, PSLVERR, back-to-back, bad-select and timeout.
module apb_master_gen #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_SLAVES  = 2,
  parameter int SEL_W       = $clog2(NUM_SLAVES + 1),
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [SEL_W-1:0]      req_sel,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : {CNT_W{1'b0}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  done_s;
  logic                  abort_s;
  logic                  req_ready_s;
  logic                  accept_s;
  logic                  sel_ok_s;
  logic                  load_s;
  logic [NUM_SLAVES-1:0] sel_onehot_s;

  logic                  rsp_valid_r;
  logic [DATA_W-1:0]     rsp_rdata_r;
  logic                  rsp_err_r;
  logic                  rsp_timeout_r;
  logic [NUM_SLAVES-1:0] psel_r;
  logic                  penable_r;
  logic                  pwrite_r;
  logic [ADDR_W-1:0]     paddr_r;
  logic [DATA_W-1:0]     pwdata_r;
  logic [STRB_W-1:0]     pstrb_r;

  // Handshake decode: completion/abort detection, select validity and one-hot select.
  always_comb begin
    done_s      = (state_r == ST_ACCESS) && pready;
    abort_s     = (state_r == ST_ACCESS) && !pready && TO_EN && (cnt_r == CNT_MAX);
    req_ready_s = (state_r == ST_IDLE) || done_s;
    accept_s    = req_valid && req_ready_s;
    sel_ok_s    = (req_sel != {SEL_W{1'b0}}) && (req_sel <= SEL_W'(NUM_SLAVES));
    load_s      = accept_s && sel_ok_s;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_onehot_s[i] = (req_sel == SEL_W'(i + 1));
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = sel_ok_s ? ST_SETUP : ST_ERR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: state_nxt_s = ST_ACCESS;
      ST_ACCESS: begin
        if (done_s) begin
          // Back-to-back: a request taken on the completing edge skips IDLE.
          if (accept_s) begin
            state_nxt_s = sel_ok_s ? ST_SETUP : ST_ERR;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (abort_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_ERR:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, timeout counter, registered APB outputs and response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      psel_r        <= {NUM_SLAVES{1'b0}};
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_W{1'b0}};
      pwdata_r      <= {DATA_W{1'b0}};
      pstrb_r       <= {STRB_W{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      case (state_r)
        ST_SETUP: begin
          penable_r <= 1'b1;
          cnt_r     <= {CNT_W{1'b0}};
        end
        ST_ACCESS: begin
          if (done_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= pslverr;
            if (!pwrite_r) begin
              rsp_rdata_r <= prdata;
            end
            penable_r <= 1'b0;
            psel_r    <= {NUM_SLAVES{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
          end else if (abort_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            penable_r     <= 1'b0;
            psel_r        <= {NUM_SLAVES{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_ERR: begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b1;
        end
        default: begin
        end
      endcase
      // APB address/data only move when a valid request is taken, so idle bus stays quiet.
      if (load_s) begin
        psel_r   <= sel_onehot_s;
        pwrite_r <= req_write;
        paddr_r  <= req_addr;
        pwdata_r <= req_wdata;
        pstrb_r  <= req_write ? req_strb : {STRB_W{1'b0}};
      end
    end
  end

  assign req_ready   = req_ready_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;
  assign psel        = psel_r;
  assign penable     = penable_r;
  assign pwrite      = pwrite_r;
  assign paddr       = paddr_r;
  assign pwdata      = pwdata_r;
  assign pstrb       = pstrb_r;

endmodule
